// File: rtl/upsample_pkg.sv
// upsample shared types and constants.
// Reciprocal helper feeds the interpolation weight when UPSAMPLE_INTERP_EN is set.
package upsample_pkg;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq_sample_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int RECIP_W = 16;
  localparam int ACC_W   = 17;

  function automatic logic [31:0] recip(
    input int unsigned out_rate
  );
    longint unsigned num;
    num = 64'd1 << 32;
    return 32'(num / out_rate);
  endfunction

endpackage

// File: rtl/upsample_if.sv
// AXI-Stream style valid/ready bundle for one I/Q stream.
// Master drives valid/data, slave drives ready.
interface upsample_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/upsample_lerp16.sv
// lerp16: one-channel linear interpolation, f = prev + floor(d*w / 2^16).
// Used only when UPSAMPLE_INTERP_EN is defined.
module lerp16
  import upsample_pkg::*;
(
  input  logic signed [15:0]        prev,
  input  logic signed [15:0]        cur,
  input  logic        [RECIP_W-1:0] w,
  output logic signed [15:0]        f
);

  logic signed [16:0] d;
  logic signed [33:0] prod;

  assign d    = 17'(cur) - 17'(prev);
  assign prod = 34'(d) * $signed({1'b0, w});
  // w < 2^16 keeps the sum inside the 16-bit range
  assign f    = 16'(34'(prev) + (prod >>> 16));

endmodule

// File: rtl/upsample.sv
// upsample: 20 -> 122.88 MSPS I/Q rate converter with phase accumulator.
// Define UPSAMPLE_INTERP_EN for linear interpolation; default is zero-order hold.
module upsample
  import upsample_pkg::*;
#(
  parameter int SAMPLE_RATE_IN  = 20_000,
  parameter int SAMPLE_RATE_OUT = 122_880
) (
  input  logic       s00_axis_aclk,
  input  logic       s00_axis_areset,
  upsample_if.slave  s00,
  upsample_if.master m00,
  output logic       underrun
);

  localparam logic [ACC_W:0] STEP  = SAMPLE_RATE_IN[ACC_W:0];
  localparam logic [ACC_W:0] LIMIT = SAMPLE_RATE_OUT[ACC_W:0];

  state_t             state;
  state_t             state_n;
  iq_sample_t         nxt;
  logic               nxt_valid;
  iq_sample_t         cur;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     a;
  iq_sample_t         out_data;
  logic               out_valid;
  iq_sample_t         f;
  logic               step;
  logic               wrap;
  logic               load;
  logic               pop;
  logic               starve;
  logic               push;

  assign s00.tready = ~nxt_valid;
  assign m00.tvalid = out_valid;
  assign m00.tdata  = out_data;

  assign push = s00.tvalid & ~nxt_valid;
  assign step = (state == RUN) & (~out_valid | m00.tready);
  assign a    = {1'b0, acc} + STEP;
  assign wrap = a >= LIMIT;

`ifdef UPSAMPLE_INTERP_EN
  localparam logic [31:0] RECIP = recip(SAMPLE_RATE_OUT);

  iq_sample_t         prev;
  logic [RECIP_W-1:0] w;
  logic [48:0]        wprod;

  assign wprod = 49'(acc) * 49'(RECIP);
  assign w     = RECIP_W'(wprod >> RECIP_W);

  lerp16 u_lerp_i (
    .prev (prev.i),
    .cur  (cur.i),
    .w    (w),
    .f    (f.i)
  );

  lerp16 u_lerp_q (
    .prev (prev.q),
    .cur  (cur.q),
    .w    (w),
    .f    (f.q)
  );
`else
  assign f = cur;
`endif

  always_comb begin
    state_n = state;
    load    = 1'b0;
    pop     = 1'b0;
    starve  = 1'b0;
    unique case (state)
      IDLE: begin
        if (nxt_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (step && wrap) begin
          if (nxt_valid) begin
            pop = 1'b1;
          end else begin
            starve  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // push never coincides with load/pop: both need opposite nxt_valid
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      nxt       <= '0;
      nxt_valid <= 1'b0;
      cur       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
`ifdef UPSAMPLE_INTERP_EN
      prev      <= '0;
`endif
    end else begin
      if (push) begin
        nxt       <= s00.tdata;
        nxt_valid <= 1'b1;
      end
      if (load || pop) begin
        nxt_valid <= 1'b0;
        cur       <= nxt;
      end
      if (load) begin
        acc <= '0;
      end
`ifdef UPSAMPLE_INTERP_EN
      if (load) begin
        prev <= nxt;
      end else if (pop) begin
        prev <= cur;
      end
`endif
      if (step) begin
        out_data  <= f;
        out_valid <= 1'b1;
        acc       <= wrap ? ACC_W'(a - LIMIT)
                          : ACC_W'(a);
      end else if (m00.tready) begin
        out_valid <= 1'b0;
      end
      if (starve) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_upsample.sv
// Directed bench for upsample: reset, rate/underrun, long run,
// backpressure and hold/interpolation values.
module tb_upsample;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic underrun;

  upsample_if s_if ();
  upsample_if m_if ();

  upsample dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00             (s_if),
    .m00             (m_if),
    .underrun        (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ins[$];
  logic [31:0] beats[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_q[$];
  int stab_err;
  int first_ur;
  int tv_after;
  int timeout;

  function automatic logic [15:0] lerp(
    input logic [15:0] p,
    input logic [15:0] c,
    input longint      acc
  );
    longint w, d, t;
    w = (acc * 34952) >>> 16;
    d = longint'($signed(c)) - longint'($signed(p));
    t = (d * w) >>> 16;
    return 16'(longint'($signed(p)) + t);
  endfunction

  task automatic build_expect();
    longint acc = 0;
    int idx = 0;
    logic [31:0] cur, prev;
    exp_q.delete();
    cur  = ins[0];
    prev = ins[0];
    forever begin
`ifdef UPSAMPLE_INTERP_EN
      exp_q.push_back({lerp(prev[31:16], cur[31:16], acc),
                       lerp(prev[15:0], cur[15:0], acc)});
`else
      exp_q.push_back(cur);
`endif
      acc += 20000;
      if (acc >= 122880) begin
        acc -= 122880;
        idx++;
        if (idx >= ins.size()) break;
        prev = cur;
        cur  = ins[idx];
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int max_cyc, input int stall_pct);
    int sent = 0;
    int quiet = 0;
    int ur_cyc = -1;
    logic stall = 1'b0;
    logic [31:0] held = '0;
    beats.delete();
    stab_err = 0;
    first_ur = -1;
    tv_after = -1;
    timeout  = 1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== held))
        stab_err++;
      if (ur_cyc >= 0 && c == ur_cyc + 1)
        tv_after = int'(m_if.tvalid);
      if (first_ur < 0 && underrun === 1'b1) begin
        first_ur = beats.size();
        ur_cyc   = c;
      end
      s_if.tvalid = (sent < ins.size());
      s_if.tdata  = (sent < ins.size()) ? ins[sent] : '0;
      if (s_if.tvalid && s_if.tready) sent++;
      m_if.tready = ($urandom_range(99) >= stall_pct);
      if (m_if.tvalid && m_if.tready) beats.push_back(m_if.tdata);
      stall = m_if.tvalid && !m_if.tready;
      held  = m_if.tdata;
      quiet = (sent == ins.size() && !m_if.tvalid) ? quiet + 1 : 0;
      if (quiet >= 12 && c > ur_cyc + 1) begin
        timeout = 0;
        break;
      end
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    #1;
    n_cmp++;
    if (m_if.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid);
    end
    n_cmp++;
    if (s_if.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %b want 1", s_if.tready);
    end
    do_reset();
    ins = '{32'h0001_0002};
    drive(200, 0);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_underrun: got %b want 1", underrun);
    end
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h1234_5678;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (m_if.tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL streaming_tvalid: got %b want 1", m_if.tvalid);
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h2222_3333;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_out: got v=%b d=%h want v=0 d=0",
               m_if.tvalid, m_if.tdata);
    end
    n_cmp++;
    if (underrun !== 1'b0 || s_if.tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_flags: got ur=%b rdy=%b want ur=0 rdy=1",
               underrun, s_if.tready);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_if.tvalid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL discard_after_reset: got %0d beats want 0", seen);
    end
  endtask

  task automatic test_rate_underrun();
    int want_run[5] = '{7, 6, 6, 6, 6};
    int run;
    do_reset();
    ins.delete();
    for (int k = 1; k <= 5; k++)
      ins.push_back({16'(k * 100), 16'(-k)});
    drive(300, 0);
    n_cmp++;
    if (timeout !== 0) begin
      n_fail++;
      $display("FAIL rate_timeout: got %0d want 0", timeout);
    end
    n_cmp++;
    if (beats.size() !== 31) begin
      n_fail++;
      $display("FAIL rate_total: got %0d want 31", beats.size());
    end
    for (int k = 0; k < 5; k++) begin
      run = 0;
      foreach (beats[b]) if (beats[b] === ins[k]) run++;
      n_cmp++;
      if (run !== want_run[k]) begin
        n_fail++;
        $display("FAIL rate_run%0d: got %0d want %0d", k, run, want_run[k]);
      end
    end
    n_cmp++;
    if (first_ur !== 30) begin
      n_fail++;
      $display("FAIL underrun_at: got %0d want 30 accepted", first_ur);
    end
    n_cmp++;
    if (tv_after !== 0) begin
      n_fail++;
      $display("FAIL tvalid_after_last: got %0d want 0", tv_after);
    end
  endtask

  task automatic test_long_run();
    int bad = 0;
    int at = -1;
    do_reset();
    ins.delete();
    for (int k = 0; k < 1000; k++) ins.push_back($urandom);
    build_expect();
    drive(8000, 0);
    n_cmp++;
    if (beats.size() !== 6144 || timeout !== 0) begin
      n_fail++;
      $display("FAIL long_count: got %0d (to=%0d) want 6144",
               beats.size(), timeout);
    end
    n_cmp++;
    if (first_ur !== 6143) begin
      n_fail++;
      $display("FAIL long_underrun_at: got %0d want 6143", first_ur);
    end
    foreach (exp_q[k]) begin
      if (k >= beats.size() || beats[k] !== exp_q[k]) begin
        bad++;
        if (at < 0) at = k;
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL long_order: got %0d wrong beats (first %0d) want 0",
               bad, at);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    ins.delete();
    for (int k = 0; k < 200; k++) ins.push_back($urandom);
    build_expect();
    drive(3000, 0);
    ref_q = beats;
    n_cmp++;
    if (ref_q.size() !== 1229 || ref_q !== exp_q) begin
      n_fail++;
      $display("FAIL ready_seq: got %0d beats want %0d (model)",
               ref_q.size(), exp_q.size());
    end
    do_reset();
    drive(6000, 30);
    n_cmp++;
    if (stab_err !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d changes want 0", stab_err);
    end
    foreach (ref_q[k])
      if (k >= beats.size() || beats[k] !== ref_q[k]) bad++;
    n_cmp++;
    if (bad !== 0 || beats.size() !== ref_q.size()) begin
      n_fail++;
      $display("FAIL stall_seq: got %0d beats, %0d wrong, want %0d, 0",
               beats.size(), bad, ref_q.size());
    end
  endtask

  task automatic test_hold_values();
    logic [15:0] want8;
    int bad = 0;
`ifdef UPSAMPLE_INTERP_EN
    want8 = 16'd2282;
`else
    want8 = 16'd16384;
`endif
    do_reset();
    ins = '{32'h0000_0000, 32'h4000_0000};
    drive(200, 0);
    n_cmp++;
    if (beats.size() !== 13) begin
      n_fail++;
      $display("FAIL hold_total: got %0d want 13", beats.size());
    end
    for (int k = 0; k < 7; k++)
      if (k >= beats.size() || beats[k] !== 32'h0) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_first7: got %0d nonzero want 0", bad);
    end
    n_cmp++;
    if (beats.size() < 8 || beats[7] !== {want8, 16'h0000}) begin
      n_fail++;
      $display("FAIL beat8: got %h want %h",
               (beats.size() >= 8) ? beats[7] : 32'hx, {want8, 16'h0});
    end
`ifndef UPSAMPLE_INTERP_EN
    bad = 0;
    for (int k = 7; k < 13; k++)
      if (k >= beats.size() || beats[k] !== 32'h4000_0000) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL zoh_8to13: got %0d wrong want 0", bad);
    end
`endif
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_rate_underrun();
    test_long_run();
    test_backpressure();
    test_hold_values();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
